// File: rtl/n64_joybus_rx.sv
// Multi-channel N64 joybus line receiver: synchronise, decode bits by low-pulse width,
// assemble MSB-first bytes and end frames on idle. Define N64_GLITCH_FILTER_EN for a 3-sample majority filter.
module n64_joybus_rx #(
    parameter int CHANNELS     = 1,
    parameter int CLKS_PER_US  = 4,
    parameter int THRESH_CLKS  = 2*CLKS_PER_US,
    parameter int MAX_LOW_CLKS = 5*CLKS_PER_US,
    parameter int IDLE_CLKS    = 5*CLKS_PER_US
) (
    input  logic                  sample_clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [CHANNELS-1:0]   data,
    output logic [8*CHANNELS-1:0] byte_data,
    output logic [CHANNELS-1:0]   byte_valid,
    output logic [CHANNELS-1:0]   frame_done,
    output logic [3*CHANNELS-1:0] frame_residual,
    output logic [CHANNELS-1:0]   bit_error,
    output logic [CHANNELS-1:0]   busy
);
    localparam int CNT_MAX = (MAX_LOW_CLKS > IDLE_CLKS) ? MAX_LOW_CLKS : IDLE_CLKS;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    localparam logic [CNT_W-1:0] THRESH_C   = CNT_W'(THRESH_CLKS);
    localparam logic [CNT_W-1:0] LOW_LAST_C = CNT_W'(MAX_LOW_CLKS - 1);
    localparam logic [CNT_W-1:0] IDLE_LAST_C = CNT_W'(IDLE_CLKS - 1);
    localparam logic [CNT_W-1:0] ONE_C      = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, LOW, HIGH, ERROR} state_t;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic       sync1, sync2;
        logic       line;
        state_t     state;
        logic [CNT_W-1:0] cnt;
        logic [2:0] bitcnt;
        logic [7:0] sr;
        logic [7:0] bd;
        logic [2:0] res;
        logic       bv, fd, be;
        logic       bit_val;

        // NOTE: synchroniser flops reset to 1 (idle level) so release of reset never looks like a falling edge.
        always_ff @(posedge sample_clk or negedge reset) begin
            if (!reset) begin
                sync1 <= 1'b1;
                sync2 <= 1'b1;
            end else begin
                sync1 <= data[c];
                sync2 <= sync1;
            end
        end

`ifdef N64_GLITCH_FILTER_EN
        logic [1:0] hist;

        always_ff @(posedge sample_clk or negedge reset) begin
            if (!reset) begin
                hist <= 2'b11;
            end else begin
                hist <= {hist[0], sync2};
            end
        end

        // Majority of the current and two previous samples; a lone flipped sample never wins.
        assign line = (sync2 & hist[0]) | (sync2 & hist[1]) | (hist[0] & hist[1]);
`else
        assign line = sync2;
`endif

        assign bit_val = (cnt < THRESH_C);

        // NOTE: every state update is non-blocking so the whole channel advances on one consistent snapshot.
        always_ff @(posedge sample_clk or negedge reset) begin
            if (!reset) begin
                state  <= IDLE;
                cnt    <= '0;
                bitcnt <= '0;
                sr     <= '0;
                bd     <= '0;
                res    <= '0;
                bv     <= 1'b0;
                fd     <= 1'b0;
                be     <= 1'b0;
            end else begin
                bv <= 1'b0;
                fd <= 1'b0;
                be <= 1'b0;
                if (!enable) begin
                    state  <= IDLE;
                    cnt    <= '0;
                    bitcnt <= '0;
                end else begin
                    unique case (state)
                        IDLE: begin
                            if (!line) begin
                                state  <= LOW;
                                cnt    <= ONE_C;
                                bitcnt <= '0;
                            end
                        end
                        LOW: begin
                            if (!line) begin
                                if (cnt == LOW_LAST_C) begin
                                    state <= ERROR;
                                    be    <= 1'b1;
                                    cnt   <= '0;
                                end else begin
                                    cnt <= cnt + ONE_C;
                                end
                            end else begin
                                sr     <= {sr[6:0], bit_val};
                                bitcnt <= bitcnt + 3'd1;
                                if (bitcnt == 3'd7) begin
                                    bv <= 1'b1;
                                    bd <= {sr[6:0], bit_val};
                                end
                                state <= HIGH;
                                cnt   <= ONE_C;
                            end
                        end
                        HIGH: begin
                            if (!line) begin
                                state <= LOW;
                                cnt   <= ONE_C;
                            end else if (cnt == IDLE_LAST_C) begin
                                fd    <= 1'b1;
                                res   <= bitcnt;
                                bd    <= sr;
                                state <= IDLE;
                                cnt   <= '0;
                            end else begin
                                cnt <= cnt + ONE_C;
                            end
                        end
                        ERROR: begin
                            // Wait for an unbroken idle stretch before listening again.
                            if (!line) begin
                                cnt <= '0;
                            end else if (cnt == IDLE_LAST_C) begin
                                state <= IDLE;
                                cnt   <= '0;
                            end else begin
                                cnt <= cnt + ONE_C;
                            end
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
        end

        assign byte_data[8*c +: 8]      = bd;
        assign frame_residual[3*c +: 3] = res;
        assign byte_valid[c]            = bv;
        assign frame_done[c]            = fd;
        assign bit_error[c]             = be;
        assign busy[c]                  = (state != IDLE);
    end

endmodule

// File: tb/tb_n64_joybus_rx.sv
// Self-checking bench for n64_joybus_rx (2 channels, 4 MHz): frame vector table plus
// hand-written stuck-low, glitch, reset and enable sequences, checked by a per-channel scoreboard.
module tb_n64_joybus_rx;
    localparam int CH = 2;

    logic              clk;
    logic              reset;
    logic              enable;
    logic              pin0, pin1;
    logic [CH-1:0]     data;
    logic [8*CH-1:0]   byte_data;
    logic [CH-1:0]     byte_valid;
    logic [CH-1:0]     frame_done;
    logic [3*CH-1:0]   frame_residual;
    logic [CH-1:0]     bit_error;
    logic [CH-1:0]     busy;

    int checks   = 0;
    int failures = 0;

    assign data = {pin1, pin0};

    n64_joybus_rx #(.CHANNELS(CH), .CLKS_PER_US(4)) dut (
        .sample_clk     (clk),
        .reset          (reset),
        .enable         (enable),
        .data           (data),
        .byte_data      (byte_data),
        .byte_valid     (byte_valid),
        .frame_done     (frame_done),
        .frame_residual (frame_residual),
        .bit_error      (bit_error),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum logic [1:0] {K_BYTE, K_FRAME, K_ERR} kind_t;
    typedef struct {
        kind_t      kind;
        logic [7:0] data;
        logic [2:0] res;
    } ev_t;

    ev_t q0[$];
    ev_t q1[$];

    typedef struct {
        int         ch;
        int         nbytes;
        logic [23:0] bytes;
        bit         stop;
        logic [2:0] exp_res;
        logic [7:0] exp_low;
    } frame_vec_t;

    frame_vec_t vecs[4];

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] res_mask(logic [2:0] r);
        logic [8:0] m;
        m = (9'd1 << r) - 9'd1;
        return m[7:0];
    endfunction

    task automatic push(int c, kind_t k, logic [7:0] d, logic [2:0] r);
        ev_t e;
        e.kind = k;
        e.data = d;
        e.res  = r;
        if (c == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic got_event(int c, kind_t k, logic [7:0] d, logic [2:0] r);
        ev_t e;
        int  n;
        n = (c == 0) ? q0.size() : q1.size();
        if (n == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_strobe ch%0d: got kind=%0d data=0x%0h res=%0d, required no strobe", c, k, d, r);
            return;
        end
        if (c == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        check($sformatf("ch%0d_kind", c), 32'(k), 32'(e.kind));
        if (e.kind != K_ERR)   check($sformatf("ch%0d_data", c), 32'(d), 32'(e.data));
        if (e.kind == K_FRAME) check($sformatf("ch%0d_residual", c), 32'(r), 32'(e.res));
    endtask

    // Scoreboard side: every strobe must match the next expectation for its channel.
    always @(negedge clk) begin
        if (reset) begin
            for (int c = 0; c < CH; c++) begin
                if (byte_valid[c])
                    got_event(c, K_BYTE, byte_data[8*c +: 8], 3'd0);
                if (frame_done[c])
                    got_event(c, K_FRAME, byte_data[8*c +: 8] & res_mask(frame_residual[3*c +: 3]),
                              frame_residual[3*c +: 3]);
                if (bit_error[c])
                    got_event(c, K_ERR, 8'h00, 3'd0);
            end
        end
    end

    task automatic set_pin(int c, logic v);
        if (c == 0) pin0 = v;
        else        pin1 = v;
    endtask

    task automatic hold(int c, logic v, int n);
        set_pin(c, v);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(int c, logic b);
        hold(c, 1'b0, b ? 4 : 12);
        hold(c, 1'b1, b ? 12 : 4);
    endtask

    task automatic send_byte(int c, logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(c, b[i]);
    endtask

    task automatic send_frame(int c, logic [23:0] bytes, int n, bit stop);
        logic [23:0] b;
        b = bytes;
        for (int j = 0; j < n; j++) send_byte(c, b[23-8*j -: 8]);
        if (stop) hold(c, 1'b0, 4);
        hold(c, 1'b1, 30);
    endtask

    initial begin
        logic [23:0] vb;
        logic        busy_or;

        vecs[0] = '{ch: 0, nbytes: 1, bytes: 24'h01_00_00, stop: 1'b1, exp_res: 3'd1, exp_low: 8'h01};
        vecs[1] = '{ch: 0, nbytes: 3, bytes: 24'hA5_3C_FF, stop: 1'b0, exp_res: 3'd0, exp_low: 8'h00};
        vecs[2] = '{ch: 1, nbytes: 2, bytes: 24'h5A_C3_00, stop: 1'b1, exp_res: 3'd1, exp_low: 8'h01};
        vecs[3] = '{ch: 1, nbytes: 1, bytes: 24'h00_00_00, stop: 1'b0, exp_res: 3'd0, exp_low: 8'h00};

        reset  = 1'b0;
        enable = 1'b1;
        pin0   = 1'b1;
        pin1   = 1'b1;
        #1;
        check("reset_byte_data", 32'(byte_data), 32'h0);
        check("reset_residual", 32'(frame_residual), 32'h0);
        check("reset_strobes", 32'({byte_valid, frame_done, bit_error}), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);

        // Table-driven frames.
        for (int i = 0; i < 4; i++) begin
            vb = vecs[i].bytes;
            for (int j = 0; j < vecs[i].nbytes; j++)
                push(vecs[i].ch, K_BYTE, vb[23-8*j -: 8], 3'd0);
            push(vecs[i].ch, K_FRAME, vecs[i].exp_low, vecs[i].exp_res);
            send_frame(vecs[i].ch, vecs[i].bytes, vecs[i].nbytes, vecs[i].stop);
            check($sformatf("vec%0d_drained", i), 32'(q0.size() + q1.size()), 32'd0);
            check($sformatf("vec%0d_idle", i), 32'(busy), 32'd0);
        end

        // Stuck low: error on the 20th low sample, idle again after 20 high samples.
        push(0, K_ERR, 8'h00, 3'd0);
        hold(0, 1'b0, 24);
        check("err_before_release", 32'(q0.size()), 32'd0);
        check("err_busy_while_low", 32'(busy[0]), 32'd1);
        set_pin(0, 1'b1);
        repeat (20) @(negedge clk);
        check("err_busy_before_idle", 32'(busy[0]), 32'd1);
        repeat (4) @(negedge clk);
        check("err_busy_after_idle", 32'(busy[0]), 32'd0);
        repeat (5) @(negedge clk);

        // Single-cycle low glitch on an idle line.
`ifndef N64_GLITCH_FILTER_EN
        push(0, K_FRAME, 8'h01, 3'd1);
`endif
        busy_or = 1'b0;
        set_pin(0, 1'b0);
        @(negedge clk);
        set_pin(0, 1'b1);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            busy_or = busy_or | busy[0];
        end
`ifdef N64_GLITCH_FILTER_EN
        check("glitch_busy", 32'(busy_or), 32'd0);
`else
        check("glitch_busy", 32'(busy_or), 32'd1);
`endif
        check("glitch_drained", 32'(q0.size()), 32'd0);

        // Reset four bits into a byte, then a clean 0x80 frame.
        for (int i = 0; i < 4; i++) send_bit(0, 1'b1);
        check("midbyte_busy", 32'(busy[0]), 32'd1);
        reset = 1'b0;
        #1;
        check("midreset_byte_data", 32'(byte_data), 32'h0);
        check("midreset_residual", 32'(frame_residual), 32'h0);
        check("midreset_busy", 32'(busy), 32'h0);
        repeat (3) @(negedge clk);
        check("midreset_strobes", 32'({byte_valid, frame_done, bit_error}), 32'h0);
        reset = 1'b1;
        hold(0, 1'b1, 5);
        push(0, K_BYTE, 8'h80, 3'd0);
        push(0, K_FRAME, 8'h00, 3'd0);
        send_frame(0, 24'h80_00_00, 1, 1'b0);
        check("post_reset_drained", 32'(q0.size()), 32'd0);

        // Two channels concurrently, ch1 three cycles behind.
        push(0, K_BYTE, 8'h12, 3'd0);
        push(0, K_FRAME, 8'h00, 3'd0);
        push(1, K_BYTE, 8'h34, 3'd0);
        push(1, K_FRAME, 8'h00, 3'd0);
        fork
            send_frame(0, 24'h12_00_00, 1, 1'b0);
            begin
                hold(1, 1'b1, 3);
                send_frame(1, 24'h34_00_00, 1, 1'b0);
            end
        join
        check("dual_drained", 32'(q0.size() + q1.size()), 32'd0);

        // Same traffic with enable dropped mid-frame: no strobes expected.
        fork
            send_frame(0, 24'h12_00_00, 1, 1'b0);
            begin
                hold(1, 1'b1, 3);
                send_frame(1, 24'h34_00_00, 1, 1'b0);
            end
            begin
                repeat (50) @(negedge clk);
                check("busy_before_disable", 32'(busy), 32'h3);
                enable = 1'b0;
                repeat (2) @(negedge clk);
                check("busy_after_disable", 32'(busy), 32'h0);
            end
        join
        check("busy_disabled_end", 32'(busy), 32'h0);
        enable = 1'b1;
        repeat (30) @(negedge clk);
        check("busy_reenabled", 32'(busy), 32'h0);
        check("final_drained_ch0", 32'(q0.size()), 32'd0);
        check("final_drained_ch1", 32'(q1.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
